// File: rtl/axi_ost_alloc_pkg.sv
// Shared sizing for the outstanding-transaction allocator and the order tracker.
package axi_ost_alloc_pkg;

  localparam int unsigned OST_DEPTH_DEF  = 16;
  localparam int unsigned ID_WIDTH_DEF   = 4;
  localparam int unsigned ADDR_WIDTH_DEF = 32;
  localparam int unsigned LEN_WIDTH_DEF  = 8;

  // Pointer width carries one extra code so a count of OST_DEPTH fits.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Index width for selecting one of n slots (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned PTR_WIDTH_DEF = ptr_width(OST_DEPTH_DEF);

endpackage

// File: rtl/axi_ost_alloc_if.sv
// AXI address-channel request (AR or AW) seen by the slot allocator.
interface axi_ost_alloc_if
  import axi_ost_alloc_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = ID_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF
);

  logic                  s_avalid;
  logic                  s_aready;
  logic [ID_WIDTH-1:0]   s_aid;
  logic [ADDR_WIDTH-1:0] s_aaddr;
  logic [LEN_WIDTH-1:0]  s_alen;

  modport master (
    output s_avalid, s_aid, s_aaddr, s_alen,
    input  s_aready
  );

  modport slave (
    input  s_avalid, s_aid, s_aaddr, s_alen,
    output s_aready
  );

endinterface

// File: rtl/axi_ost_alloc_ffs.sv
// Find-first-set: index of the lowest set bit of vec.
module axi_ffs
  import axi_ost_alloc_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned IDX_WIDTH = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0]     vec,
  output logic [IDX_WIDTH-1:0] index,
  output logic                 found
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        index = IDX_WIDTH'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_ost_alloc.sv
// Outstanding-transaction slot allocator: hands out the lowest free slot on
// each accepted request and frees slots on the last response beat.
module axi_ost_alloc
  import axi_ost_alloc_pkg::*;
#(
  parameter int unsigned OST_DEPTH  = OST_DEPTH_DEF,
  parameter int unsigned ID_WIDTH   = ID_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF,
  localparam int unsigned PTR_WIDTH = ptr_width(OST_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axi_ost_alloc_if.slave        req,
  output logic                  push,
  output logic [ID_WIDTH-1:0]   push_id,
  output logic [PTR_WIDTH-1:0]  push_ptr,
  input  logic                  rel_valid,
  input  logic [PTR_WIDTH-1:0]  rel_ptr,
  input  logic [PTR_WIDTH-1:0]  rd_ptr,
  output logic [ID_WIDTH-1:0]   rd_id,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [LEN_WIDTH-1:0]  rd_len,
  output logic [OST_DEPTH-1:0]  slot_busy,
  output logic [PTR_WIDTH-1:0]  ost_cnt,
  output logic                  full,
  output logic                  empty,
  output logic                  rel_err
);

  localparam int unsigned IDX_WIDTH = idx_width(OST_DEPTH);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
  } slot_t;

  slot_t                 slots [OST_DEPTH];
  slot_t                 rd_slot;
  logic [OST_DEPTH-1:0]  free_vec;
  logic [IDX_WIDTH-1:0]  tgt_idx;
  logic                  tgt_found;
  logic [IDX_WIDTH-1:0]  rel_idx;
  logic [IDX_WIDTH-1:0]  rd_idx;
  logic                  rel_in_range;
  logic                  rel_ok;
  logic [OST_DEPTH-1:0]  busy_nxt;
  logic [PTR_WIDTH-1:0]  cnt_nxt;

  assign free_vec = ~slot_busy;

  axi_ffs #(.WIDTH(OST_DEPTH)) u_ffs (
    .vec   (free_vec),
    .index (tgt_idx),
    .found (tgt_found)
  );

  // Ready depends only on registered occupancy, never on s_avalid.
  assign req.s_aready = ~full;

  // Allocation is zero-latency: push accompanies the handshake itself.
  assign push     = req.s_avalid & ~full & tgt_found;
  assign push_id  = req.s_aid;
  assign push_ptr = PTR_WIDTH'(tgt_idx);

  // A release counts only when it names an in-range, currently busy slot.
  assign rel_idx      = IDX_WIDTH'(rel_ptr);
  assign rel_in_range = (rel_ptr < PTR_WIDTH'(OST_DEPTH));
  assign rel_ok       = rel_valid & rel_in_range & slot_busy[rel_idx];

  // Next busy bitmap and occupancy; allocation and release never hit one slot.
  always_comb begin
    busy_nxt = slot_busy;
    cnt_nxt  = ost_cnt;
    if (rel_ok) begin
      busy_nxt[rel_idx] = 1'b0;
    end
    if (push) begin
      busy_nxt[tgt_idx] = 1'b1;
    end
    case ({push, rel_ok})
      2'b10:   cnt_nxt = ost_cnt + PTR_WIDTH'(1);
      2'b01:   cnt_nxt = ost_cnt - PTR_WIDTH'(1);
      default: cnt_nxt = ost_cnt;
    endcase
  end

  // Occupancy, flags and sticky release error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_busy <= '0;
      ost_cnt   <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      rel_err   <= 1'b0;
    end else begin
      slot_busy <= busy_nxt;
      ost_cnt   <= cnt_nxt;
      full      <= (cnt_nxt == PTR_WIDTH'(OST_DEPTH));
      empty     <= (cnt_nxt == '0);
      if (rel_valid && !rel_ok) begin
        rel_err <= 1'b1;
      end
    end
  end

  // Slot payload capture; released slots keep stale contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(OST_DEPTH); i++) begin
        slots[i] <= '0;
      end
    end else if (push) begin
      slots[tgt_idx] <= '{id: req.s_aid, addr: req.s_aaddr, len: req.s_alen};
    end
  end

  // Combinational slot lookup; out-of-range pointers read as zero.
  assign rd_idx = IDX_WIDTH'(rd_ptr);

  always_comb begin
    rd_slot = '0;
    if (rd_ptr < PTR_WIDTH'(OST_DEPTH)) begin
      rd_slot = slots[rd_idx];
    end
  end

  assign rd_id   = rd_slot.id;
  assign rd_addr = rd_slot.addr;
  assign rd_len  = rd_slot.len;

endmodule

// File: tb/tb_axi_ost_alloc.sv
// Scoreboard bench for axi_ost_alloc against a slot-table reference model.
module tb_axi_ost_alloc;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned IDW   = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned LW    = 8;
  localparam int unsigned PW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          push;
  logic [IDW-1:0] push_id;
  logic [PW-1:0] push_ptr;
  logic          rel_valid;
  logic [PW-1:0] rel_ptr;
  logic [PW-1:0] rd_ptr;
  logic [IDW-1:0] rd_id;
  logic [AW-1:0] rd_addr;
  logic [LW-1:0] rd_len;
  logic [DEPTH-1:0] slot_busy;
  logic [PW-1:0] ost_cnt;
  logic          full;
  logic          empty;
  logic          rel_err;

  always #5 clk = ~clk;

  axi_ost_alloc_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) req_if ();

  axi_ost_alloc #(
    .OST_DEPTH(DEPTH), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req_if),
    .push(push), .push_id(push_id), .push_ptr(push_ptr),
    .rel_valid(rel_valid), .rel_ptr(rel_ptr),
    .rd_ptr(rd_ptr), .rd_id(rd_id), .rd_addr(rd_addr), .rd_len(rd_len),
    .slot_busy(slot_busy), .ost_cnt(ost_cnt), .full(full), .empty(empty),
    .rel_err(rel_err)
  );

  typedef struct packed {
    logic           push;
    logic [IDW-1:0] push_id;
    logic [PW-1:0]  push_ptr;
    logic           aready;
    logic           full;
    logic           empty;
    logic [PW-1:0]  cnt;
    logic [DEPTH-1:0] busy;
    logic           err;
    logic [IDW-1:0] rd_id;
    logic [AW-1:0]  rd_addr;
    logic [LW-1:0]  rd_len;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: a table of slots with occupancy and a sticky error.
  bit             m_busy [DEPTH];
  logic [IDW-1:0] m_id   [DEPTH];
  logic [AW-1:0]  m_addr [DEPTH];
  logic [LW-1:0]  m_len  [DEPTH];
  int             m_cnt;
  bit             m_err;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < int'(DEPTH); i++) begin
      m_busy[i] = 1'b0;
      m_id[i]   = '0;
      m_addr[i] = '0;
      m_len[i]  = '0;
    end
    m_cnt = 0;
    m_err = 1'b0;
  endfunction

  // Monitor: compares DUT outputs against the queued expectation each cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("push", 64'(push), 64'(e.push));
      if (e.push) begin
        chk("push_id", 64'(push_id), 64'(e.push_id));
        chk("push_ptr", 64'(push_ptr), 64'(e.push_ptr));
      end
      chk("s_aready", 64'(req_if.s_aready), 64'(e.aready));
      chk("full", 64'(full), 64'(e.full));
      chk("empty", 64'(empty), 64'(e.empty));
      chk("ost_cnt", 64'(ost_cnt), 64'(e.cnt));
      chk("slot_busy", 64'(slot_busy), 64'(e.busy));
      chk("rel_err", 64'(rel_err), 64'(e.err));
      chk("rd_id", 64'(rd_id), 64'(e.rd_id));
      chk("rd_addr", 64'(rd_addr), 64'(e.rd_addr));
      chk("rd_len", 64'(rd_len), 64'(e.rd_len));
    end
  end

  // One clock of stimulus: drive, queue the expected response, advance model.
  task automatic cyc(input bit av, input int aid, input logic [AW-1:0] addr, input int len,
                     input bit rv, input int rp, input int rdp);
    exp_t e;
    int   tgt;
    bit   hs;
    bit   rok;
    req_if.s_avalid = av;
    req_if.s_aid    = IDW'(aid);
    req_if.s_aaddr  = addr;
    req_if.s_alen   = LW'(len);
    rel_valid       = rv;
    rel_ptr         = PW'(rp);
    rd_ptr          = PW'(rdp);
    tgt = -1;
    for (int i = DEPTH - 1; i >= 0; i--) if (!m_busy[i]) tgt = i;
    hs  = av && (m_cnt < int'(DEPTH)) && (tgt >= 0);
    rok = rv && (rp < int'(DEPTH)) && m_busy[rp % DEPTH];
    e = '0;
    e.push     = hs;
    e.push_id  = IDW'(aid);
    e.push_ptr = PW'(tgt < 0 ? 0 : tgt);
    e.aready   = (m_cnt != int'(DEPTH));
    e.full     = (m_cnt == int'(DEPTH));
    e.empty    = (m_cnt == 0);
    e.cnt      = PW'(m_cnt);
    for (int i = 0; i < int'(DEPTH); i++) e.busy[i] = m_busy[i];
    e.err      = m_err;
    if (rdp < int'(DEPTH)) begin
      e.rd_id   = m_id[rdp];
      e.rd_addr = m_addr[rdp];
      e.rd_len  = m_len[rdp];
    end
    exp_q.push_back(e);
    @(posedge clk);
    if (rok) m_busy[rp] = 1'b0;
    if (hs) begin
      m_busy[tgt] = 1'b1;
      m_id[tgt]   = IDW'(aid);
      m_addr[tgt] = addr;
      m_len[tgt]  = LW'(len);
    end
    m_cnt = m_cnt + int'(hs) - int'(rok);
    if (rv && !rok) m_err = 1'b1;
    #1;
  endtask

  task automatic idle_inputs();
    req_if.s_avalid = 1'b0;
    req_if.s_aid    = '0;
    req_if.s_aaddr  = '0;
    req_if.s_alen   = '0;
    rel_valid       = 1'b0;
    rel_ptr         = '0;
    rd_ptr          = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_clear();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Picks a busy slot from the model when one exists, else an arbitrary index.
  function automatic int pick_busy();
    int s;
    s = int'($urandom_range(0, DEPTH - 1));
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (m_busy[(s + k) % DEPTH]) return (s + k) % DEPTH;
    end
    return s;
  endfunction

  initial begin
    idle_inputs();
    model_clear();

    // Reset state, then fill the table in order.
    do_reset();
    cyc(0, 0, '0, 0, 0, 0, 0);
    for (int i = 0; i < int'(DEPTH); i++) cyc(1, i, AW'(32'h100 * i), i, 0, 0, i);
    cyc(1, 0, 32'hdead_0000, 1, 0, 0, 15);
    // Free slot 5 in a full table and reuse it.
    cyc(0, 0, '0, 0, 1, 5, 5);
    cyc(1, 3, 32'h0000_5550, 2, 0, 0, 5);
    cyc(0, 0, '0, 0, 0, 0, 5);

    // Simultaneous allocate and release with slots 0-3 busy.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, i, AW'(i), i, 0, 0, 0);
    cyc(1, 12, 32'h0000_0c00, 3, 1, 1, 1);
    cyc(0, 0, '0, 0, 0, 0, 1);
    cyc(1, 13, 32'h0000_0d00, 4, 0, 0, 1);

    // Invalid releases: idle slot, then out of range.
    do_reset();
    cyc(0, 0, '0, 0, 1, 7, 7);
    cyc(0, 0, '0, 0, 1, 16, 16);
    cyc(0, 0, '0, 0, 0, 0, 0);

    // Payload capture and lookup.
    do_reset();
    cyc(1, 9, 32'h1000_0040, 7, 0, 0, 0);
    cyc(0, 0, '0, 0, 0, 0, 0);
    cyc(0, 0, '0, 0, 0, 0, 17);

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bit av;
      bit rv;
      int rp;
      av = ($urandom_range(0, 99) < 60);
      rv = ($urandom_range(0, 99) < 45);
      rp = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 31)) : pick_busy();
      cyc(av, int'($urandom_range(0, 15)), $urandom, int'($urandom_range(0, 255)),
          rv, rp, int'($urandom_range(0, 18)));
    end

    // Asynchronous reset in the middle of a cycle with eight slots busy.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, i, AW'(32'h40 * i), i, 0, 0, 0);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_aready", 64'(req_if.s_aready), 64'd1);
    chk("async_rst_push", 64'(push), 64'd0);
    chk("async_rst_busy", 64'(slot_busy), 64'd0);
    chk("async_rst_cnt", 64'(ost_cnt), 64'd0);
    chk("async_rst_full", 64'(full), 64'd0);
    chk("async_rst_empty", 64'(empty), 64'd1);
    chk("async_rst_err", 64'(rel_err), 64'd0);
    chk("async_rst_rd_addr", 64'(rd_addr), 64'd0);
    model_clear();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, 0, '0, 0, 0, 0, 0);
    cyc(1, 5, 32'h2000_0000, 1, 0, 0, 0);
    cyc(0, 0, '0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
